uart_tx_sequencer: RTL and testbench

- Transmit-side controller for the UART bring-up path.
- Buffers bytes from a producer in a small FIFO and owns the bit-period divider, in the same way as the baud generator (CLKF/BR division).
- Sequences start, data, optional parity and stop bits onto the serial line.
- Restarts the divider at each frame start so every bit is exactly one full bit period wide.

---
 rtl/uart_tx_sequencer.sv | 148 ++++++++++++++
 tb/tb_uart_tx_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer
//   Transmit-side UART controller. Bytes from a producer are buffered in a
//   small circular FIFO and serialized as start, 8 data bits (LSB first),
//   optional parity and 1..2 stop bits. The bit-period divider restarts at
//   every frame start, so each bit lasts exactly CLKF/BR clock cycles.
//   Frames queued in the FIFO are sent back-to-back with no idle gap.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-low reset
//   tx_data     byte offered by the producer
//   tx_valid    producer offers tx_data
//   tx_ready    FIFO not full; a push happens on tx_valid && tx_ready
//   tx          registered serial line, idle high
//   busy        high whenever a frame is in progress (state != IDLE)
//   fifo_count  current FIFO occupancy
module uart_tx_sequencer #(
  parameter int BR         = 9600,
  parameter int CLKF       = 50000000,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CPB = CLKF / BR;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] DIV_LAST  = CW'(CPB - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t          state, state_nxt;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [AW:0]     count;
  logic [CW-1:0]   div;
  logic [2:0]      bidx;
  logic [7:0]      shift, shift_nxt;
  logic [7:0]      byte_q;
  logic            push, pop, empty, bit_end, tx_nxt;

  function automatic logic parity_bit(input logic [7:0] b);
    // Even parity makes the total number of ones even; odd makes it odd.
    return (PARITY == 2) ? ~^b : ^b;
  endfunction

  assign tx_ready   = (count != FIFO_FULL);
  assign push       = tx_valid && tx_ready;
  assign empty      = (count == '0);
  assign bit_end    = (state != IDLE) && (div == DIV_LAST);
  assign busy       = (state != IDLE);
  assign fifo_count = count;

  // Next-state logic; pop is issued from IDLE or from the last stop bit.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE:  if (!empty) begin
               pop       = 1'b1;
               state_nxt = START;
             end
      START: if (bit_end) state_nxt = DATA;
      DATA:  if (bit_end && bidx == 3'd7) state_nxt = (PARITY != 0) ? PAR : STOP;
      PAR:   if (bit_end) state_nxt = STOP;
      STOP:  if (bit_end && bidx == STOP_LAST) begin
               if (!empty) begin
                 pop       = 1'b1;
                 state_nxt = START;
               end else begin
                 state_nxt = IDLE;
               end
             end
      default: state_nxt = IDLE;
    endcase
  end

  // The line level is computed from the next state so tx changes on the
  // same edge as the state register.
  always_comb begin
    shift_nxt = shift;
    if (pop)
      shift_nxt = mem[rptr];
    else if (state == DATA && bit_end)
      shift_nxt = {1'b0, shift[7:1]};

    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      PAR:     tx_nxt = parity_bit(byte_q);
      default: tx_nxt = 1'b1;
    endcase
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      tx    <= 1'b1;
      div   <= '0;
      bidx  <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      tx    <= tx_nxt;

      // A fresh START always begins a full bit period.
      if (state_nxt == IDLE || (state_nxt == START && state != START) || bit_end)
        div <= '0;
      else
        div <= div + 1'b1;

      // bidx counts data bits in DATA and stop bits in STOP.
      if (bit_end)
        bidx <= (state_nxt != state) ? 3'd0 : bidx + 3'd1;

      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Data registers: contents are don't-care while the pointers are reset.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= tx_data;
    shift <= shift_nxt;
    if (pop) byte_q <= mem[rptr];
  end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
module tb_uart_tx_sequencer;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int NDUT  = 4;
  localparam int PAR_C  [NDUT] = '{0, 1, 2, 0};
  localparam int STOP_C [NDUT] = '{1, 1, 1, 2};

  logic       clk;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_w   [NDUT];
  logic       busy_w [NDUT];
  logic       rdy_w  [NDUT];
  logic [2:0] cnt_w  [NDUT];

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  uart_tx_sequencer #(.BR(1), .CLKF(4), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_none (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(rdy_w[0]),
    .tx(tx_w[0]), .busy(busy_w[0]), .fifo_count(cnt_w[0]));
  uart_tx_sequencer #(.BR(1), .CLKF(4), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_even (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(rdy_w[1]),
    .tx(tx_w[1]), .busy(busy_w[1]), .fifo_count(cnt_w[1]));
  uart_tx_sequencer #(.BR(1), .CLKF(4), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_odd (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(rdy_w[2]),
    .tx(tx_w[2]), .busy(busy_w[2]), .fifo_count(cnt_w[2]));
  uart_tx_sequencer #(.BR(1), .CLKF(4), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_stop2 (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(rdy_w[3]),
    .tx(tx_w[3]), .busy(busy_w[3]), .fifo_count(cnt_w[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a queue of accepted bytes and, per DUT, the position
  // (in clock cycles) inside the frame currently on the line (-1 = idle).
  logic [7:0] mq  [NDUT][$];
  logic [7:0] cur [NDUT];
  int         pos [NDUT];

  function automatic int frame_cycles(input int d);
    return (1 + 8 + ((PAR_C[d] != 0) ? 1 : 0) + STOP_C[d]) * CPB;
  endfunction

  function automatic logic frame_bit(input int d, input logic [7:0] b, input int n);
    if (n == 0) return 1'b0;
    if (n <= 8) return b[n-1];
    if (n == 9 && PAR_C[d] == 1) return ^b;
    if (n == 9 && PAR_C[d] == 2) return ~^b;
    return 1'b1;
  endfunction

  function automatic logic exp_tx(input int d);
    if (pos[d] < 0) return 1'b1;
    return frame_bit(d, cur[d], pos[d] / CPB);
  endfunction

  function automatic bit models_idle();
    for (int d = 0; d < NDUT; d++)
      if (pos[d] >= 0 || mq[d].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  initial for (int d = 0; d < NDUT; d++) pos[d] = -1;

  always @(posedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      int sz;
      bit acc;
      if (!reset) begin
        mq[d].delete();
        pos[d] = -1;
      end else begin
        sz  = mq[d].size();
        acc = tx_valid && (sz != DEPTH);
        if (pos[d] < 0) begin
          if (sz != 0) begin
            cur[d] = mq[d].pop_front();
            pos[d] = 0;
          end
        end else begin
          pos[d] = pos[d] + 1;
          if (pos[d] == frame_cycles(d)) begin
            if (sz != 0) begin
              cur[d] = mq[d].pop_front();
              pos[d] = 0;
            end else begin
              pos[d] = -1;
            end
          end
        end
        if (acc) mq[d].push_back(tx_data);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < NDUT; d++) begin
        check_val($sformatf("model_tx[%0d]", d), tx_w[d], exp_tx(d));
        check_val($sformatf("model_busy[%0d]", d), busy_w[d], (pos[d] >= 0));
        check_val($sformatf("model_count[%0d]", d), cnt_w[d], mq[d].size());
        check_val($sformatf("model_ready[%0d]", d), rdy_w[d], (mq[d].size() != DEPTH));
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (!models_idle() && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!models_idle())
      check_val("drain_timeout", busy_w[0] | busy_w[1] | busy_w[2] | busy_w[3], 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [9:0] exp_a5;
    exp_a5   = 10'b1101001010;   // bit k of the frame at index k
    reset    = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 8'h3C;

    // Reset held for 3 cycles with tx_valid asserted.
    @(posedge clk);
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("rst_tx", tx_w[0], 1);
      check_val("rst_busy", busy_w[0], 0);
      check_val("rst_count", cnt_w[0], 0);
    end

    // Release reset and push 0xA5 on the very next edge.
    reset   = 1'b1;
    tx_data = 8'hA5;
    @(negedge clk);
    tx_valid = 1'b0;
    check_val("first_push_count", cnt_w[0], 1);
    check_val("push_edge_tx", tx_w[0], 1);
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      check_val("a5_bit", tx_w[0], exp_a5[k / CPB]);
      check_val("a5_busy", busy_w[0], 1);
    end
    @(negedge clk);
    check_val("a5_idle_busy", busy_w[0], 0);
    check_val("a5_idle_tx", tx_w[0], 1);
    wait_idle();

    // Parity of 0x07: even -> 1, odd -> 0; 11-bit frame is 44 cycles.
    tx_valid = 1'b1;
    tx_data  = 8'h07;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (38) @(negedge clk);
    check_val("par_even", tx_w[1], 1);
    check_val("par_odd", tx_w[2], 0);
    repeat (6) @(negedge clk);
    check_val("par_busy_last", busy_w[1], 1);
    @(negedge clk);
    check_val("par_busy_end", busy_w[1], 0);
    wait_idle();

    // Back-to-back frames with two stop bits.
    tx_valid = 1'b1;
    tx_data  = 8'h55;
    @(negedge clk);
    tx_data  = 8'h0F;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (43) @(negedge clk);
    check_val("b2b_stop", tx_w[3], 1);
    check_val("b2b_busy_stop", busy_w[3], 1);
    @(negedge clk);
    check_val("b2b_start", tx_w[3], 0);
    check_val("b2b_busy_start", busy_w[3], 1);
    wait_idle();

    // FIFO full: six bytes offered on consecutive cycles.
    @(negedge clk);
    tx_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tx_data = 8'($urandom);
      @(negedge clk);
      if (i == 4) begin
        check_val("full_count", cnt_w[0], 4);
        check_val("full_ready", rdy_w[0], 0);
      end
    end
    tx_valid = 1'b0;
    wait_idle();

    // Reset during data bit 3 of 0xFF with two bytes queued.
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    @(negedge clk);
    tx_data  = 8'($urandom);
    @(negedge clk);
    tx_data  = 8'($urandom);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (15) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("midrst_tx", tx_w[0], 1);
    check_val("midrst_count", cnt_w[0], 0);
    check_val("midrst_busy", busy_w[0], 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (60) @(negedge clk);
    check_val("midrst_no_frames", busy_w[0], 0);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      tx_valid = ($urandom_range(0, 2) == 0);
      tx_data  = 8'($urandom);
      @(negedge clk);
    end
    tx_valid = 1'b0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
